io_device: RTL and testbench
============================

# io_device

Device-side endpoint of the I/O unit's 5-bit tape-code handshakes: the tape reader/puncher adapter. The input channel is a transmitter. It buffers host-supplied input codes and presents them to the I/O unit using the 4-phase rdy/ack protocol the unit receives with. The output channel is a receiver. It accepts codes the I/O unit presents, acknowledges them, and buffers them for the host. It sits between the I/O unit and the simulation host or panel tape model.

## Interface
- TX_AW, 4: input FIFO address width; depth is 2^TX_AW.
- RX_AW, 4: output FIFO address width; depth is 2^RX_AW.
- TX_GAP, 2: idle cycles inserted between input codes (reader speed), 0..255.
- ACK_DELAY, 1: cycles between seeing output rdy and asserting ack (punch latency), 0..255.

- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- tx_valid  in  1  host offers an input code.
- tx_ready  out  1  input FIFO not full.
- tx_data  in  5  code to push.
- tx_level  out  TX_AW+1  input FIFO occupancy.
- reader_enable  in  1  level; when low, no new code is presented (an in-flight handshake completes).
- input_rdy_to_io  out  1  handshake, to I/O unit.
- input_ack_from_io  in  1  handshake, from I/O unit.
- input_data_to_io  out  5  code, to I/O unit.
- output_rdy_from_io  in  1  handshake, from I/O unit.
- output_ack_to_io  out  1  handshake, to I/O unit.
- output_data_from_io  in  5  code, from I/O unit.
- rx_valid  out  1  output FIFO not empty.
- rx_ready  in  1  host pops.
- rx_data  out  5  head of output FIFO (first-word fall-through).
- rx_level  out  RX_AW+1  output FIFO occupancy.

## Operation
- FIFOs: circular, with pointers that wrap at 2^AW.
  - Push when valid&&ready; pop when valid&&ready.
  - A simultaneous push and pop leaves the level unchanged.
  - Push when full is ignored (tx_ready=0). Pop when empty is ignored.
- TX FSM (one-hot): TX_IDLE, TX_RDY, TX_WAIT, TX_GAP.
  - TX_IDLE: if reader_enable && tx_level!=0, load input_data_to_io from the FIFO head and pop it; go to TX_RDY with input_rdy_to_io=1.
  - TX_RDY: hold rdy and data. On input_ack_from_io=1, drop rdy and go to TX_WAIT.
  - TX_WAIT: hold data. On input_ack_from_io=0, load the gap counter with TX_GAP and go to TX_GAP.
  - TX_GAP: decrement the counter; at 0 go to TX_IDLE. With TX_GAP=0 this state lasts exactly 1 cycle.
  - input_data_to_io changes only on the TX_IDLE→TX_RDY transition.
- RX FSM (one-hot): RX_IDLE, RX_DLY, RX_ACK.
  - RX_IDLE: on output_rdy_from_io=1 && rx_level<2^RX_AW, load the delay counter with ACK_DELAY and go to RX_DLY.
  - RX_DLY: decrement; at 0, push output_data_from_io into the FIFO, set output_ack_to_io=1, and go to RX_ACK. The data is sampled on this cycle.
  - RX_ACK: on output_rdy_from_io=0, drop ack and go to RX_IDLE.
  - A full FIFO stalls in RX_IDLE with ack low. This is backpressure; nothing is dropped.
- reader_enable falling during TX_RDY/TX_WAIT does not abort; the handshake completes.
- Reset at any point: FIFOs are emptied, both FSMs return to IDLE, and all handshake outputs drop asynchronously.

## Timing
- Reset values:
  - tx_ready=1, tx_level=0
  - input_rdy_to_io=0, input_data_to_io=0
  - output_ack_to_io=0
  - rx_valid=0, rx_data=0, rx_level=0
- All outputs are registered, except tx_ready, rx_valid and rx_data, which decode registered state.
- Push to rdy: a code pushed at edge N is visible in tx_level at N+1. With the FSM in TX_IDLE and enabled, input_rdy_to_io rises at N+2.
- rdy falls one edge after ack is sampled high. The next rdy rises no earlier than TX_GAP+2 edges after ack is sampled low.
- Output channel: ack rises ACK_DELAY+1 edges after rdy is sampled high. ack falls one edge after rdy is sampled low.
- rx_valid rises on the same edge ack rises.
- Against the I/O unit with TX_GAP=0, the input channel carries one code per at least 5 cycles.

## Test plan
- Reset mid-handshake: assert resetn=0 while in TX_RDY with 3 codes queued → all outputs take their reset values immediately; tx_level=0 after release; no rdy until a new push.
- Input transfer: push 5'b10011, 5'b00110 with reader_enable=1 and a bench responder that acks 1 cycle after rdy and releases 1 cycle after rdy drops → codes appear on input_data_to_io in order, each stable through ack; tx_level goes 2→0; rdy pulses are separated by ≥TX_GAP+2 cycles.
- Output transfer: bench drives output_rdy_from_io=1 with data 5'b11110 and drops rdy when ack is seen → ack rises after ACK_DELAY+1 edges; rx_data=5'b11110, rx_level=1; ack falls 1 edge after rdy falls.
- Full/backpressure:
  - Fill the output FIFO to 16 without popping. A 17th rdy gets no ack.
  - Pop 1 → the stalled code is then acked and stored; rx_level=16.
  - Push 17 codes with the reader disabled → the 17th is refused (tx_ready=0).
- Simultaneous events: with rx_level=4, a push (ack edge) and a pop happen on the same cycle → rx_level stays 4 and order is preserved. reader_enable falls during TX_RDY → the handshake completes and no further rdy is issued.
- Loopback: drive 11 codes 5'b00000, 5'b10000…5'b11001 through both channels via a bench model → rx_data sequence equals tx_data sequence and both FIFOs end empty.

Source files
------------

// File: rtl/io_device.sv
// Tape reader/puncher adapter: buffers host codes and sends them over the 4-phase
// input handshake, and acknowledges and buffers codes arriving on the output handshake.

module io_device_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [4:0]    push_data,
    input  logic          pop,
    output logic [4:0]    head,
    output logic [AW:0]   level,
    output logic          full
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [4:0]    mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level_q == DEPTH);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// state      | meaning
// TX_IDLE    | waiting for a queued code while the reader is enabled
// TX_RDY     | rdy high with code, waiting for ack
// TX_WAIT    | rdy low, waiting for ack to drop
// TX_GAP_ST  | reader-speed idle gap before the next code
// RX_IDLE    | waiting for rdy with room in the output FIFO
// RX_DLY     | punch latency countdown before ack
// RX_ACK     | code stored, ack high until rdy drops
module io_device #(
    parameter int TX_AW     = 4,
    parameter int RX_AW     = 4,
    parameter int TX_GAP    = 2,
    parameter int ACK_DELAY = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [4:0]       tx_data,
    output logic [TX_AW:0]   tx_level,
    input  logic             reader_enable,
    output logic             input_rdy_to_io,
    input  logic             input_ack_from_io,
    output logic [4:0]       input_data_to_io,
    input  logic             output_rdy_from_io,
    output logic             output_ack_to_io,
    input  logic [4:0]       output_data_from_io,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [4:0]       rx_data,
    output logic [RX_AW:0]   rx_level
);

    localparam logic [7:0] GAP_LOAD = 8'(TX_GAP);
    localparam logic [7:0] DLY_LOAD = 8'(ACK_DELAY);

    typedef enum logic [3:0] {
        TX_IDLE   = 4'b0001,
        TX_RDY    = 4'b0010,
        TX_WAIT   = 4'b0100,
        TX_GAP_ST = 4'b1000
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'b001,
        RX_DLY  = 3'b010,
        RX_ACK  = 3'b100
    } rx_state_t;

    tx_state_t  tx_state_q, tx_state_d;
    logic       tx_rdy_q, tx_rdy_d;
    logic [4:0] tx_code_q, tx_code_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       tx_pop;
    logic       tx_full;
    logic [4:0] tx_head;

    rx_state_t  rx_state_q, rx_state_d;
    logic       rx_ack_q, rx_ack_d;
    logic [7:0] dly_cnt_q, dly_cnt_d;
    logic       rx_push;
    logic       rx_full;
    logic [4:0] rx_head;

    io_device_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (resetn),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .level     (tx_level),
        .full      (tx_full)
    );

    io_device_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (resetn),
        .push      (rx_push),
        .push_data (output_data_from_io),
        .pop       (rx_ready),
        .head      (rx_head),
        .level     (rx_level),
        .full      (rx_full)
    );

    assign tx_ready         = !tx_full;
    assign rx_valid         = (rx_level != '0);
    assign rx_data          = rx_valid ? rx_head : 5'd0;
    assign input_rdy_to_io  = tx_rdy_q;
    assign input_data_to_io = tx_code_q;
    assign output_ack_to_io = rx_ack_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_rdy_d   = tx_rdy_q;
        tx_code_d  = tx_code_q;
        gap_cnt_d  = gap_cnt_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (reader_enable && (tx_level != '0)) begin
                    tx_pop     = 1'b1;
                    tx_code_d  = tx_head;
                    tx_rdy_d   = 1'b1;
                    tx_state_d = TX_RDY;
                end
            end
            TX_RDY: begin
                if (input_ack_from_io) begin
                    tx_rdy_d   = 1'b0;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!input_ack_from_io) begin
                    gap_cnt_d  = GAP_LOAD;
                    tx_state_d = TX_GAP_ST;
                end
            end
            TX_GAP_ST: begin
                if (gap_cnt_q == 8'd0) tx_state_d = TX_IDLE;
                else                   gap_cnt_d  = gap_cnt_q - 8'd1;
            end
            default: begin
                tx_rdy_d   = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Only entered with room in the FIFO, so the push in RX_DLY is never lost.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_ack_d   = rx_ack_q;
        dly_cnt_d  = dly_cnt_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (output_rdy_from_io && !rx_full) begin
                    dly_cnt_d  = DLY_LOAD;
                    rx_state_d = RX_DLY;
                end
            end
            RX_DLY: begin
                if (dly_cnt_q == 8'd0) begin
                    rx_push    = 1'b1;
                    rx_ack_d   = 1'b1;
                    rx_state_d = RX_ACK;
                end else begin
                    dly_cnt_d  = dly_cnt_q - 8'd1;
                end
            end
            RX_ACK: begin
                if (!output_rdy_from_io) begin
                    rx_ack_d   = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_ack_d   = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= TX_IDLE;
            tx_rdy_q   <= 1'b0;
            tx_code_q  <= 5'd0;
            gap_cnt_q  <= 8'd0;
            rx_state_q <= RX_IDLE;
            rx_ack_q   <= 1'b0;
            dly_cnt_q  <= 8'd0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_rdy_q   <= tx_rdy_d;
            tx_code_q  <= tx_code_d;
            gap_cnt_q  <= gap_cnt_d;
            rx_state_q <= rx_state_d;
            rx_ack_q   <= rx_ack_d;
            dly_cnt_q  <= dly_cnt_d;
        end
    end

endmodule

// File: tb/tb_io_device.sv
// Directed-plus-random bench for io_device: queue-based models of both FIFOs and
// bench-side handshake partners for the I/O unit and host.

module tb_io_device;

    localparam int TX_GAP    = 2;
    localparam int ACK_DELAY = 1;
    localparam int DEPTH     = 16;

    logic       clk;
    logic       resetn;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] tx_data;
    logic [4:0] tx_level;
    logic       reader_enable;
    logic       input_rdy_to_io;
    logic       input_ack_from_io;
    logic [4:0] input_data_to_io;
    logic       output_rdy_from_io;
    logic       output_ack_to_io;
    logic [4:0] output_data_from_io;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] rx_data;
    logic [4:0] rx_level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rel_cyc;

    logic [4:0] tx_exp [$];
    logic [4:0] rx_exp [$];

    logic [4:0] code;
    logic [4:0] r;
    logic [4:0] codes [11];
    int         t;
    bit         seen;

    io_device #(
        .TX_AW(4), .RX_AW(4), .TX_GAP(TX_GAP), .ACK_DELAY(ACK_DELAY)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .tx_data             (tx_data),
        .tx_level            (tx_level),
        .reader_enable       (reader_enable),
        .input_rdy_to_io     (input_rdy_to_io),
        .input_ack_from_io   (input_ack_from_io),
        .input_data_to_io    (input_data_to_io),
        .output_rdy_from_io  (output_rdy_from_io),
        .output_ack_to_io    (output_ack_to_io),
        .output_data_from_io (output_data_from_io),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .rx_data             (rx_data),
        .rx_level            (rx_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_ready", tx_ready, 1);
        check("rst_tx_level", tx_level, 0);
        check("rst_in_rdy", input_rdy_to_io, 0);
        check("rst_in_data", input_data_to_io, 0);
        check("rst_out_ack", output_ack_to_io, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_level", rx_level, 0);
    endtask

    task automatic tx_push(input logic [4:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_exp.push_back(d);
        tick();
        tx_valid = 1'b0;
    endtask

    // Bench plays the I/O unit receiving one input code.
    task automatic tx_handshake(input bit drop_en, output logic [4:0] got);
        int         w;
        logic [4:0] e;
        w = 0;
        while (input_rdy_to_io !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        check("tx_rdy_rise", input_rdy_to_io, 1);
        if (rel_cyc >= 0) check("tx_rdy_spacing", (cyc - rel_cyc) >= TX_GAP + 2, 1);
        got = input_data_to_io;
        e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 5'bx;
        check("tx_code", got, e);
        if (drop_en) reader_enable = 1'b0;
        tick();
        check("tx_rdy_hold", input_rdy_to_io, 1);
        check("tx_data_hold", input_data_to_io, got);
        input_ack_from_io = 1'b1;
        tick();
        check("tx_rdy_fall", input_rdy_to_io, 0);
        check("tx_data_through_ack", input_data_to_io, got);
        input_ack_from_io = 1'b0;
        tick();
        rel_cyc = cyc;
    endtask

    // Bench plays the I/O unit presenting one output code.
    task automatic rx_handshake(input logic [4:0] d);
        int   w;
        logic pv;
        output_rdy_from_io  = 1'b1;
        output_data_from_io = d;
        w  = 0;
        pv = rx_valid;
        do begin
            pv = rx_valid;
            tick();
            w++;
        end while (output_ack_to_io !== 1'b1 && w < 100);
        check("rx_ack_rise", output_ack_to_io, 1);
        check("rx_ack_latency", w, ACK_DELAY + 2);
        if (rx_exp.size() == 0) check("rx_valid_before_ack", pv, 0);
        rx_exp.push_back(d);
        check("rx_valid_with_ack", rx_valid, 1);
        check("rx_level", rx_level, rx_exp.size());
        output_rdy_from_io  = 1'b0;
        output_data_from_io = 5'($urandom);
        tick();
        check("rx_ack_fall", output_ack_to_io, 0);
    endtask

    task automatic rx_pop();
        logic [4:0] e;
        e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 5'bx;
        check("rx_valid_pop", rx_valid, 1);
        check("rx_data", rx_data, e);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        resetn              = 1'b0;
        tx_valid            = 1'b0;
        tx_data             = 5'd0;
        reader_enable       = 1'b0;
        input_ack_from_io   = 1'b0;
        output_rdy_from_io  = 1'b0;
        output_data_from_io = 5'd0;
        rx_ready            = 1'b0;
        rel_cyc             = -1;
        codes[0] = 5'b00000;
        for (int i = 1; i < 11; i++) codes[i] = 5'(15 + i);

        #23;
        check_reset_outputs();
        tick();
        resetn = 1'b1;
        tick();

        // Input transfer of two fixed codes
        tx_push(5'b10011);
        tx_push(5'b00110);
        check("tx_level_two", tx_level, 2);
        reader_enable = 1'b1;
        tx_handshake(1'b0, code);
        tx_handshake(1'b0, code);
        check("tx_level_drained", tx_level, 0);

        // Push-to-rdy latency from an idle, enabled reader
        repeat (6) tick();
        r = 5'($urandom);
        tx_push(r);
        check("tx_level_after_push", tx_level, 1);
        check("tx_rdy_not_yet", input_rdy_to_io, 0);
        tick();
        check("tx_rdy_latency", input_rdy_to_io, 1);
        tx_handshake(1'b0, code);

        // Output transfer
        rx_handshake(5'b11110);
        check("rx_data_first", rx_data, 5'b11110);
        rx_pop();
        check("rx_empty_after_pop", rx_valid, 0);

        // Output FIFO full: the 17th code stalls until a pop
        for (int i = 0; i < DEPTH; i++) rx_handshake(5'($urandom));
        check("rx_level_full", rx_level, DEPTH);
        r = 5'($urandom);
        output_rdy_from_io  = 1'b1;
        output_data_from_io = r;
        repeat (6) tick();
        check("rx_stall_no_ack", output_ack_to_io, 0);
        check("rx_stall_level", rx_level, DEPTH);
        rx_pop();
        t = 0;
        while (output_ack_to_io !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        check("rx_stall_release_ack", output_ack_to_io, 1);
        rx_exp.push_back(r);
        check("rx_stall_release_level", rx_level, DEPTH);
        output_rdy_from_io = 1'b0;
        tick();
        check("rx_stall_ack_fall", output_ack_to_io, 0);
        for (int i = 0; i < DEPTH; i++) rx_pop();
        check("rx_drained", rx_valid, 0);

        // Input FIFO full with the reader disabled
        reader_enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) tx_push(5'($urandom));
        check("tx_level_full", tx_level, DEPTH);
        check("tx_ready_full", tx_ready, 0);
        tx_valid = 1'b1;
        tx_data  = 5'($urandom);
        tick();
        tx_valid = 1'b0;
        check("tx_overflow_ignored", tx_level, DEPTH);
        reader_enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) tx_handshake(1'b0, code);
        check("tx_full_drained", tx_level, 0);

        // Push on the ack edge coincides with a host pop at level 4
        for (int i = 0; i < 4; i++) rx_handshake(5'($urandom));
        r = 5'($urandom);
        output_rdy_from_io  = 1'b1;
        output_data_from_io = r;
        repeat (ACK_DELAY + 1) tick();
        check("sim_ack_not_yet", output_ack_to_io, 0);
        check("sim_pop_data", rx_data, rx_exp[0]);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        void'(rx_exp.pop_front());
        rx_exp.push_back(r);
        check("sim_ack_rise", output_ack_to_io, 1);
        check("sim_level_kept", rx_level, 4);
        output_rdy_from_io = 1'b0;
        tick();
        check("sim_ack_fall", output_ack_to_io, 0);
        for (int i = 0; i < 4; i++) rx_pop();
        check("sim_drained", rx_level, 0);

        // Reader disabled mid-handshake: completes, then no further rdy
        repeat (6) tick();
        reader_enable = 1'b0;
        tx_push(5'($urandom));
        tx_push(5'($urandom));
        reader_enable = 1'b1;
        tx_handshake(1'b1, code);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (input_rdy_to_io) seen = 1'b1;
        end
        check("tx_no_rdy_disabled", seen, 0);
        check("tx_level_left", tx_level, 1);
        reader_enable = 1'b1;
        tx_handshake(1'b0, code);

        // Reset while rdy is up with codes queued
        repeat (6) tick();
        reader_enable = 1'b0;
        for (int i = 0; i < 4; i++) tx_push(5'($urandom));
        reader_enable = 1'b1;
        t = 0;
        while (input_rdy_to_io !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        check("rst_mid_rdy_up", input_rdy_to_io, 1);
        check("rst_mid_queued", tx_level, 3);
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        tick();
        resetn = 1'b1;
        tx_exp.delete();
        rx_exp.delete();
        rel_cyc = -1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (input_rdy_to_io) seen = 1'b1;
        end
        check("rst_no_rdy_after", seen, 0);
        check("rst_tx_level_after", tx_level, 0);

        // Loopback of 11 codes through both channels
        for (int i = 0; i < 11; i++) tx_push(codes[i]);
        for (int i = 0; i < 11; i++) begin
            tx_handshake(1'b0, code);
            rx_handshake(code);
        end
        for (int i = 0; i < 11; i++) begin
            check("loop_order", rx_data, codes[i]);
            rx_pop();
        end
        check("loop_tx_empty", tx_level, 0);
        check("loop_rx_empty", rx_level, 0);
        check("loop_rx_valid", rx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
